// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_pkg
//  Description : Shared state encodings, LFSR constants and step function for
//                the reaction-time game controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package reaction_pkg;

    localparam int unsigned c_DEFAULT_TICK_DIV = 50000;

    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 taps bits 0,2,3,5
    localparam logic [15:0] c_LFSR_TAPS = 16'h002D;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE        = 3'd0;
    localparam state_t c_ST_ARM         = 3'd1;
    localparam state_t c_ST_WAIT        = 3'd2;
    localparam state_t c_ST_TIMING      = 3'd3;
    localparam state_t c_ST_DONE        = 3'd4;
    localparam state_t c_ST_FALSE_START = 3'd5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] i_val);
        return {^(i_val & c_LFSR_TAPS), i_val[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ms_tick_gen
//  Description : Free-running prescaler producing a one-cycle tick every
//                TICK_DIV clocks; restart realigns the phase to a full period.
//  Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV = c_DEFAULT_TICK_DIV
) (
    input  logic clock,
    input  logic clear,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (clear || restart) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/reaction_controller.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_controller
//  Description : Reaction-time game FSM driving the BCD millisecond counter's
//                clear/enable inputs and the stimulus/status LEDs.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV       = c_DEFAULT_TICK_DIV,
    parameter int unsigned MIN_WAIT_TICKS = 1000,
    parameter int unsigned RAND_BITS      = 11,
    parameter int unsigned TIMEOUT_TICKS  = 999
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic react,
    output logic cnt_clear,
    output logic cnt_enable,
    output logic stim_led,
    output logic done,
    output logic timeout,
    output logic early,
    output logic busy
);

    localparam int unsigned WAIT_W = $clog2(MIN_WAIT_TICKS + (2 ** RAND_BITS));

    state_t            r_state;
    logic              r_start_q;
    logic              r_react_q;
    logic              r_edge_ok;
    logic [15:0]       r_lfsr;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [9:0]        r_elapsed;
    logic              r_done;
    logic              r_timeout;
    logic              r_early;

    logic       w_tick;
    logic       w_restart;
    logic       w_start_edge;
    logic       w_react_edge;
    logic       w_wait_done;
    logic       w_cnt_enable;
    logic       w_timeout_hit;
    logic [9:0] w_elapsed_next;

    // Edges are masked for the first cycle after reset so a button held
    // through reset does not count as a fresh press.
    assign w_start_edge = r_edge_ok & start & ~r_start_q;
    assign w_react_edge = r_edge_ok & react & ~r_react_q;

    assign w_wait_done    = (r_state == c_ST_WAIT) && !w_react_edge && w_tick
                            && (r_wait_cnt <= WAIT_W'(1));
    assign w_restart      = (r_state == c_ST_ARM) || w_wait_done;
    assign w_cnt_enable   = (r_state == c_ST_TIMING) && w_tick && !w_react_edge;
    assign w_elapsed_next = r_elapsed + 10'd1;
    assign w_timeout_hit  = w_cnt_enable && (w_elapsed_next == 10'(TIMEOUT_TICKS));

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock   (clock),
        .clear   (clear),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state    <= c_ST_IDLE;
            r_start_q  <= 1'b0;
            r_react_q  <= 1'b0;
            r_edge_ok  <= 1'b0;
            r_lfsr     <= c_LFSR_SEED;
            r_wait_cnt <= '0;
            r_elapsed  <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_early    <= 1'b0;
        end else begin
            r_start_q <= start;
            r_react_q <= react;
            r_edge_ok <= 1'b1;
            r_lfsr    <= lfsr_next(r_lfsr);

            case (r_state)
                c_ST_IDLE, c_ST_DONE, c_ST_FALSE_START: begin
                    if (w_start_edge) begin
                        r_state   <= c_ST_ARM;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_early   <= 1'b0;
                    end
                end
                c_ST_ARM: begin
                    r_wait_cnt <= WAIT_W'(MIN_WAIT_TICKS) + WAIT_W'(r_lfsr[RAND_BITS-1:0]);
                    r_elapsed  <= '0;
                    r_done     <= 1'b0;
                    r_timeout  <= 1'b0;
                    r_early    <= 1'b0;
                    r_state    <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (w_react_edge) begin
                        r_state <= c_ST_FALSE_START;
                        r_early <= 1'b1;
                    end else if (w_tick) begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                        if (w_wait_done) begin
                            r_state <= c_ST_TIMING;
                        end
                    end
                end
                c_ST_TIMING: begin
                    if (w_react_edge) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end else if (w_cnt_enable) begin
                        r_elapsed <= w_elapsed_next;
                        if (w_timeout_hit) begin
                            r_state   <= c_ST_DONE;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cnt_clear  = (r_state == c_ST_ARM);
    assign cnt_enable = w_cnt_enable;
    assign stim_led   = (r_state == c_ST_TIMING);
    assign busy       = (r_state == c_ST_ARM) || (r_state == c_ST_WAIT)
                        || (r_state == c_ST_TIMING);
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign early      = r_early;

endmodule
`default_nettype wire

// File: tb/tb_reaction_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reaction_controller
//  Description : Randomized scoreboard bench for reaction_controller with a
//                trial-level reference model of the game rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_controller;

    localparam int unsigned TICK_DIV       = 4;
    localparam int unsigned MIN_WAIT_TICKS = 3;
    localparam int unsigned RAND_BITS      = 2;
    localparam int unsigned TIMEOUT_TICKS  = 999;

    localparam int K_REACT = 0;
    localparam int K_FS    = 1;
    localparam int K_TMO   = 2;
    localparam int K_SAME  = 3;
    localparam int K_ABORT = 4;

    typedef struct {
        int kind;
        int enables;
        bit done;
        bit tmo;
        bit early;
    } exp_t;

    logic clk;
    logic clear;
    logic start;
    logic react;
    logic cnt_clear;
    logic cnt_enable;
    logic stim_led;
    logic done;
    logic timeout;
    logic early;
    logic busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    exp_t exp_q[$];
    int   press_q[$];

    reaction_controller #(
        .TICK_DIV       (TICK_DIV),
        .MIN_WAIT_TICKS (MIN_WAIT_TICKS),
        .RAND_BITS      (RAND_BITS),
        .TIMEOUT_TICKS  (TIMEOUT_TICKS)
    ) dut (
        .clock      (clk),
        .clear      (clear),
        .start      (start),
        .react      (react),
        .cnt_clear  (cnt_clear),
        .cnt_enable (cnt_enable),
        .stim_led   (stim_led),
        .done       (done),
        .timeout    (timeout),
        .early      (early),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter and LFSR model: x^16+x^14+x^13+x^11+1, shifted right.
    always @(posedge clk) begin
        cyc++;
        if (clear) m_lfsr = 16'hACE1;
        else       m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    // Monitor / scoreboard
    bit   open = 0;
    bit   prev_busy = 0;
    int   n_en = 0;
    int   clr_cyc = 0;
    int   stim_cyc = -1;
    int   exp_r = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (cnt_clear) begin
            check("clear_with_enable", int'(cnt_enable), 0);
            if (open) begin
                check("spurious_cnt_clear", 1, 0);
            end else begin
                if (press_q.size() == 0) begin
                    check("unexpected_cnt_clear", 1, 0);
                    cur = '{kind: K_ABORT, enables: 0, done: 0, tmo: 0, early: 0};
                end else begin
                    check("cnt_clear_latency", cyc - press_q.pop_front(), 1);
                    cur = exp_q.pop_front();
                end
                open     = 1;
                n_en     = 0;
                clr_cyc  = cyc;
                stim_cyc = -1;
                exp_r    = int'(m_lfsr[1:0]);
            end
        end
        if (cnt_enable) begin
            if (open) n_en++;
            else      check("enable_outside_trial", 1, 0);
        end
        if (open && stim_led && stim_cyc < 0) stim_cyc = cyc;
        if (open && prev_busy && !busy) begin
            open = 0;
            check("end_stim_led", int'(stim_led), 0);
            check("end_cnt_enable", int'(cnt_enable), 0);
            case (cur.kind)
                K_FS: begin
                    check("fs_enables", n_en, 0);
                    check("fs_early", int'(early), 1);
                    check("fs_done", int'(done), 0);
                    check("fs_stim_rose", stim_cyc, -1);
                end
                K_ABORT: begin
                    check("abort_flags", int'({done, timeout, early}), 0);
                end
                default: begin
                    check("stim_delay", stim_cyc - (clr_cyc + 1),
                          (int'(MIN_WAIT_TICKS) + exp_r) * int'(TICK_DIV));
                    check("enables", n_en, cur.enables);
                    check("done", int'(done), int'(cur.done));
                    check("timeout", int'(timeout), int'(cur.tmo));
                    check("early", int'(early), int'(cur.early));
                end
            endcase
        end
        prev_busy = busy;
    end

    task automatic press_start(input exp_t e);
        @(posedge clk); #1;
        start = 1'b1;
        press_q.push_back(cyc);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_stim(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (stim_led) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("stim_led_rise_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc && busy; i++) begin
            @(posedge clk); #1;
        end
        if (busy) check("busy_drop_timeout", 1, 0);
        react = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_react(input int k);
        repeat (k) @(posedge clk);
        #1;
        react = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        react = 1'b0;
    endtask

    task automatic run_trial(input int kind, input int n);
        exp_t e;
        bit   ok;
        e = '{kind: kind, enables: 0, done: 0, tmo: 0, early: 0};
        case (kind)
            K_REACT: begin e.enables = n;             e.done = 1; end
            K_SAME:  begin e.enables = n - 1;         e.done = 1; end
            K_TMO:   begin e.enables = TIMEOUT_TICKS; e.done = 1; e.tmo = 1; end
            K_FS:    begin e.early = 1; end
            default: ;
        endcase
        press_start(e);
        case (kind)
            K_FS: begin
                pulse_react(1 + n);
                check("fs_busy", int'(busy), 0);
            end
            K_REACT: begin
                wait_stim(ok);
                if (ok) pulse_react(4 * n);
            end
            K_SAME: begin
                wait_stim(ok);
                if (ok) begin
                    repeat (5) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                    pulse_react(4 * n - 1 - 6);
                end
            end
            K_ABORT: begin
                wait_stim(ok);
                repeat (6) @(posedge clk);
                #1 clear = 1'b1;
                @(posedge clk);
                #1 clear = 1'b0;
                check("abort_stim_led", int'(stim_led), 0);
                check("abort_enable", int'(cnt_enable), 0);
                check("abort_busy", int'(busy), 0);
            end
            default: ;
        endcase
        wait_idle(5000);
        if (kind == K_TMO) begin
            repeat (90) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clear = 1'b1;
        start = 1'b1;
        react = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        check("rst_cnt_clear", int'(cnt_clear), 0);
        check("rst_cnt_enable", int'(cnt_enable), 0);
        check("rst_stim_led", int'(stim_led), 0);
        check("rst_done", int'(done), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_early", int'(early), 0);
        check("rst_busy", int'(busy), 0);
        repeat (10) @(posedge clk);
        #1;
        check("held_start_no_arm", int'(busy), 0);
        start = 1'b0;
        react = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        run_trial(K_REACT, 5);
        run_trial(K_FS, 4);
        check("early_before_rearm", int'(early), 1);
        run_trial(K_TMO, 0);
        run_trial(K_SAME, 8);
        run_trial(K_ABORT, 0);
        run_trial(K_REACT, 3);

        for (int t = 0; t < 10; t++) begin
            int kind;
            int sel;
            sel = int'($urandom_range(0, 2));
            kind = (sel == 0) ? K_REACT : (sel == 1) ? K_FS : K_SAME;
            repeat ($urandom_range(1, 7)) @(posedge clk);
            #1;
            if (kind == K_FS) run_trial(kind, int'($urandom_range(0, 8)));
            else              run_trial(kind, int'($urandom_range(3, 12)));
        end

        repeat (10) @(posedge clk);
        #1;
        check("pending_expectations", exp_q.size(), 0);
        check("trial_still_open", int'(open), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/reaction_controller.md
Name: reaction_controller

Overview:
- Control FSM for the reaction-time game. Sits directly upstream of the 3-digit BCD millisecond counter and drives its `clear` and `enable` inputs.
- Waits a pseudo-random delay, turns on the stimulus LED, then issues one counter-enable pulse per millisecond until the player reacts, a false start occurs, or 999 ms elapse.
- Outputs also drive the status LEDs.

Parameters:
- TICK_DIV, 50000: clock cycles per counter tick (50 MHz / 1 kHz); minimum 2.
- MIN_WAIT_TICKS, 1000: fixed part of the pre-stimulus delay, in ticks.
- RAND_BITS, 11: width of the random delay part; random part is 0..2^RAND_BITS-1 ticks.
- TIMEOUT_TICKS, 999: maximum enables per trial; matches the 3-digit BCD maximum.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  start button level; synchronized and debounced upstream.
- react  in  1  reaction button level; synchronized and debounced upstream.
- cnt_clear  out  1  to BCD counter `clear`; one-cycle pulse at trial start.
- cnt_enable  out  1  to BCD counter `enable`; one-cycle pulse per tick while timing.
- stim_led  out  1  stimulus LED; high only in TIMING.
- done  out  1  trial finished with a valid result; held until the next trial.
- timeout  out  1  trial ended by reaching TIMEOUT_TICKS; held like `done`.
- early  out  1  false start (react before stimulus); held until the next trial.
- busy  out  1  high in ARM, WAIT and TIMING.

Behaviour:
- Reset:
  - Clock is `clock`. Reset is `clear`: synchronous, active-high.
  - While `clear` is high at a rising edge: state=IDLE; all outputs 0; prescaler=0; wait/elapsed counters=0; edge registers=0; LFSR=16'hACE1.
  - Reset mid-trial aborts immediately. No `cnt_enable` occurs in the cycle after `clear`.
- Edge detection:
  - start_edge = start & ~start_q; react_edge = react & ~react_q.
  - The `_q` registers sample every cycle.
  - Held buttons never retrigger.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every state, so the seed depends on the player's timing.
  - Never reaches all-zero.
- Tick prescaler:
  - Counts 0..TICK_DIV-1; tick=1 when the count equals TICK_DIV-1, then wraps to 0.
  - Forced to 0 on entry to WAIT and on entry to TIMING, so the first tick is a full period.
- States and transitions:
  - IDLE: outputs held. start_edge -> ARM.
  - ARM (exactly 1 cycle):
    - cnt_clear=1.
    - wait_cnt = MIN_WAIT_TICKS + LFSR[RAND_BITS-1:0].
    - done, timeout, early cleared.
    - -> WAIT.
  - WAIT:
    - busy=1, stim_led=0.
    - react_edge -> FALSE_START, with priority over tick.
    - Else on tick: decrement wait_cnt; if wait_cnt==1 (reaching 0) -> TIMING.
  - TIMING:
    - stim_led=1.
    - cnt_enable=tick, except when react_edge occurs in the same cycle; then cnt_enable=0 (react wins).
    - elapsed increments with each cnt_enable.
    - react_edge -> DONE, done=1.
    - Else, if the enable being issued brings elapsed to TIMEOUT_TICKS -> DONE, done=1, timeout=1.
  - DONE: stim_led=0, results held, start_edge -> ARM.
  - FALSE_START: early=1, stim_led=0, start_edge -> ARM.
  - start_edge in ARM, WAIT or TIMING is ignored.
- Ordering and widths:
  - cnt_clear is never asserted in the same cycle as cnt_enable.
  - The counter therefore shows exactly the number of enables issued since ARM.
  - elapsed is 10 bits; wait_cnt is wide enough for MIN_WAIT_TICKS + 2^RAND_BITS - 1.
  - Prescaler width is clog2(TICK_DIV).

Decomposition:
- Shared package `reaction_pkg`:
  - state enum: IDLE, ARM, WAIT, TIMING, DONE, FALSE_START.
  - LFSR_SEED = 16'hACE1 and the LFSR tap mask.
  - default TICK_DIV.
- Sub-module `ms_tick_gen`:
  - ports: clock, clear, restart, tick; parameter TICK_DIV.
  - Reused by the display refresh logic.
- FSM, LFSR and edge detection stay in reaction_controller.

Test Plan (sim overrides: TICK_DIV=4, MIN_WAIT_TICKS=3, RAND_BITS=2, TIMEOUT_TICKS=999 unless noted):
1. clear high 2 cycles, with start=react=1 during reset -> all outputs 0. Holding start afterwards yields no ARM until a release and re-press.
2. start pulse -> cnt_clear high exactly 1 cycle, one cycle after the edge. stim_led rises exactly (3+r)*4 cycles after WAIT entry, with r=LFSR[1:0] sampled in ARM. react after 5 ticks -> exactly 5 cnt_enable pulses, done=1, stim_led=0.
3. react edge during WAIT -> early=1, stim_led never rises, zero cnt_enable, busy=0. Next start -> early cleared in ARM.
4. No react in TIMING -> exactly 999 cnt_enable pulses, then done=1, timeout=1, no further enables over 20 more ticks.
5. react edge in the same cycle as a tick after 7 ticks -> cnt_enable=0 that cycle, total 7 enables. Also: start pulse during TIMING -> ignored, no cnt_clear.
6. clear asserted mid-TIMING -> next cycle IDLE, stim_led=0, no cnt_enable. Subsequent trial runs normally from ARM.
